// File: rtl/mmio_responder.sv
// mmio_responder: MMIO/CSR target beside the data cache on the X-stage bus.
// Serves the 0x8xxxxxxx region (counters, counter clear, scratch) plus the tohost CSR.
module mmio_responder #(
   parameter int CNT_W = 32
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   input  logic        we,
   input  logic [1:0]  st_size,
   input  logic        re,
   input  logic [2:0]  ld_size,
   input  logic        inst_retire,
   input  logic        csr_we,
   input  logic [31:0] csr_wdata,
   output logic [31:0] rdata,
   output logic        hit,
   output logic [31:0] tohost,
   output logic        misalign
);
   localparam logic [5:0] W_CYCLE   = 6'h04;
   localparam logic [5:0] W_INSTRET = 6'h05;
   localparam logic [5:0] W_CNT_CLR = 6'h06;
   localparam logic [5:0] W_SCRATCH = 6'h07;

   logic             in_region;
   logic [5:0]       word_idx;
   logic [3:0]       lane_mask;
   logic [31:0]      lane_data;
   logic             st_misaligned;
   logic             store_ok;
   logic [31:0]      rd_sel;
   logic [31:0]      rd_shift;

   logic [CNT_W-1:0] cycle_q, cycle_d;
   logic [CNT_W-1:0] instret_q, instret_d;
   logic [31:0]      scratch_q, scratch_d;
   logic [31:0]      rd_word_q, rd_word_d;
   logic [1:0]       rd_off_q, rd_off_d;
   logic [31:0]      tohost_q, tohost_d;
   logic             hit_q, hit_d;
   logic             mis_q, mis_d;

   // Only addr[31:28] and addr[7:0] take part in the decode.
   logic unused_addr;
   assign unused_addr = ^addr[27:8];

   // NOTE: every signal gets a default before any branch so no path can infer a latch.
   always_comb begin
      in_region     = (addr[31:28] == 4'h8);
      word_idx      = addr[7:2];
      lane_mask     = 4'b1111;
      lane_data     = wdata;
      st_misaligned = 1'b0;
      case (st_size)
         2'b00: begin
            lane_mask = 4'b0001 << addr[1:0];
            lane_data = {4{wdata[7:0]}};
         end
         2'b01: begin
            lane_mask     = 4'b0011 << {addr[1], 1'b0};
            lane_data     = {2{wdata[15:0]}};
            st_misaligned = addr[0];
         end
         default: st_misaligned = (addr[1:0] != 2'b00);
      endcase
      store_ok = we && in_region && !st_misaligned;

      rd_sel = 32'h0;
      case (word_idx)
         W_CYCLE:   rd_sel = 32'(cycle_q);
         W_INSTRET: rd_sel = 32'(instret_q);
         W_SCRATCH: rd_sel = scratch_q;
         default:   rd_sel = 32'h0;
      endcase

      // Counter clear wins over the increments on the same edge.
      if (store_ok && word_idx == W_CNT_CLR) begin
         cycle_d   = '0;
         instret_d = '0;
      end else begin
         cycle_d   = cycle_q + CNT_W'(1);
         instret_d = instret_q + CNT_W'(inst_retire);
      end

      scratch_d = scratch_q;
      if (store_ok && word_idx == W_SCRATCH) begin
         for (int i = 0; i < 4; i++) begin
            if (lane_mask[i]) scratch_d[i*8 +: 8] = lane_data[i*8 +: 8];
         end
      end

      // The load samples pre-edge state, so a same-cycle store is not yet visible.
      rd_word_d = rd_word_q;
      rd_off_d  = rd_off_q;
      if (re) begin
         rd_word_d = in_region ? rd_sel : 32'h0;
         rd_off_d  = addr[1:0];
      end

      hit_d    = (re || we) ? in_region : hit_q;
      mis_d    = mis_q || (we && in_region && st_misaligned);
      tohost_d = csr_we ? csr_wdata : tohost_q;
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cycle_q   <= '0;
         instret_q <= '0;
         scratch_q <= '0;
         rd_word_q <= '0;
         rd_off_q  <= '0;
         tohost_q  <= '0;
         hit_q     <= 1'b0;
         mis_q     <= 1'b0;
      end else begin
         cycle_q   <= cycle_d;
         instret_q <= instret_d;
         scratch_q <= scratch_d;
         rd_word_q <= rd_word_d;
         rd_off_q  <= rd_off_d;
         tohost_q  <= tohost_d;
         hit_q     <= hit_d;
         mis_q     <= mis_d;
      end
   end

   // Load formatting follows the M-stage ld_size, not the one present at issue.
   always_comb begin
      rd_shift = rd_word_q >> {rd_off_q, 3'b000};
      case (ld_size)
         3'b000:  rdata = {{24{rd_shift[7]}}, rd_shift[7:0]};
         3'b001:  rdata = {{16{rd_shift[15]}}, rd_shift[15:0]};
         3'b100:  rdata = {24'h0, rd_shift[7:0]};
         3'b101:  rdata = {16'h0, rd_shift[15:0]};
         default: rdata = rd_word_q;
      endcase
   end

   assign hit      = hit_q;
   assign tohost   = tohost_q;
   assign misalign = mis_q;
endmodule

// File: tb/tb_mmio_responder.sv
// Self-checking bench for mmio_responder: directed vector table, hand sequences
// for counter/misalign/reset corners, and a randomized run against a byte-level model.
module tb_mmio_responder;
   localparam logic [2:0] LB = 3'b000, LH = 3'b001, LW = 3'b010, LBU = 3'b100, LHU = 3'b101;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] addr, wdata, csr_wdata;
   logic        we, re, inst_retire, csr_we;
   logic [1:0]  st_size;
   logic [2:0]  ld_size;
   logic [31:0] rdata, tohost;
   logic        hit, misalign;

   mmio_responder #(.CNT_W(32)) dut (
      .clk(clk), .reset(reset), .addr(addr), .wdata(wdata), .we(we), .st_size(st_size),
      .re(re), .ld_size(ld_size), .inst_retire(inst_retire), .csr_we(csr_we),
      .csr_wdata(csr_wdata), .rdata(rdata), .hit(hit), .tohost(tohost), .misalign(misalign)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   logic [31:0] m_cycle, m_instret, m_tohost, m_rd_word;
   logic [7:0]  m_sb [4];
   logic [1:0]  m_rd_off;
   logic        m_hit, m_mis;

   function automatic void model_reset();
      m_cycle = 0; m_instret = 0; m_tohost = 0; m_rd_word = 0; m_rd_off = 0;
      m_hit = 0; m_mis = 0;
      for (int i = 0; i < 4; i++) m_sb[i] = 8'h0;
   endfunction

   function automatic logic [31:0] model_read(input logic [7:0] off);
      if (off == 8'h10) return m_cycle;
      if (off == 8'h14) return m_instret;
      if (off == 8'h1C) return {m_sb[3], m_sb[2], m_sb[1], m_sb[0]};
      return 32'h0;
   endfunction

   function automatic logic [31:0] fmt(input logic [31:0] w, input logic [1:0] off,
                                       input logic [2:0] sz);
      int unsigned b = (w >> (8 * off)) & 32'hFF;
      int unsigned h = (w >> (8 * off)) & 32'hFFFF;
      case (sz)
         LB:      return (b >= 128) ? b + 32'hFFFFFF00 : b;
         LH:      return (h >= 32768) ? h + 32'hFFFF0000 : h;
         LBU:     return b;
         LHU:     return h;
         default: return w;
      endcase
   endfunction

   function automatic void model_edge();
      bit          inr = (addr[31:28] == 4'h8);
      logic [7:0]  off = addr[7:0] & 8'hFC;
      bit          mis = we && inr && ((st_size == 2'd1 && addr[0]) ||
                                       (st_size >= 2'd2 && addr[1:0] != 2'd0));
      bit          ok  = we && inr && !mis;
      if (re) begin
         m_rd_word = inr ? model_read(off) : 32'h0;
         m_rd_off  = addr[1:0];
      end
      if (re || we) m_hit = inr;
      if (mis) m_mis = 1'b1;
      if (ok && off == 8'h18) begin
         m_cycle = 0; m_instret = 0;
      end else begin
         m_cycle++;
         if (inst_retire) m_instret++;
      end
      if (ok && off == 8'h1C) begin
         case (st_size)
            2'd0: m_sb[addr[1:0]] = wdata[7:0];
            2'd1: begin
               m_sb[{addr[1], 1'b0}] = wdata[7:0];
               m_sb[{addr[1], 1'b1}] = wdata[15:8];
            end
            default: for (int i = 0; i < 4; i++) m_sb[i] = wdata[8*i +: 8];
         endcase
      end
      if (csr_we) m_tohost = csr_wdata;
   endfunction

   // ---------------- stimulus helpers ----------------
   task automatic idle();
      we = 0; re = 0; addr = 0; wdata = 0; st_size = 0; inst_retire = 0; csr_we = 0; csr_wdata = 0;
   endtask

   task automatic set_in(input logic w, input logic r, input logic [31:0] a,
                         input logic [31:0] d, input logic [1:0] s);
      we = w; re = r; addr = a; wdata = d; st_size = s;
   endtask

   // Model advances with the inputs the DUT samples; returns at the following negedge.
   task automatic clk_edge();
      model_edge();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      model_reset();
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
   endtask

   typedef struct {
      logic        we;
      logic [1:0]  st;
      logic        re;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [2:0]  lsz;
      logic        chk_rd;
      logic [31:0] exp_rd;
      logic        exp_hit;
   } vec_t;

   vec_t tbl [18];

   initial begin
      tbl[0]  = '{1'b1, 2'd0, 1'b0, 32'h8000001D, 32'h000000A5, LW,     1'b0, 32'h0,        1'b1};
      tbl[1]  = '{1'b0, 2'd0, 1'b1, 32'h8000001C, 32'h0,        LW,     1'b1, 32'h0000A500, 1'b1};
      tbl[2]  = '{1'b0, 2'd0, 1'b1, 32'h8000001D, 32'h0,        LB,     1'b1, 32'hFFFFFFA5, 1'b1};
      tbl[3]  = '{1'b0, 2'd0, 1'b1, 32'h8000001D, 32'h0,        LBU,    1'b1, 32'h000000A5, 1'b1};
      tbl[4]  = '{1'b1, 2'd2, 1'b0, 32'h8000001C, 32'hDEADBEEF, LW,     1'b0, 32'h0,        1'b1};
      tbl[5]  = '{1'b0, 2'd0, 1'b1, 32'h8000001E, 32'h0,        LH,     1'b1, 32'hFFFFDEAD, 1'b1};
      tbl[6]  = '{1'b0, 2'd0, 1'b1, 32'h8000001E, 32'h0,        LHU,    1'b1, 32'h0000DEAD, 1'b1};
      tbl[7]  = '{1'b0, 2'd0, 1'b1, 32'h8000001C, 32'h0,        LB,     1'b1, 32'hFFFFFFEF, 1'b1};
      tbl[8]  = '{1'b0, 2'd0, 1'b1, 32'h8000001F, 32'h0,        LBU,    1'b1, 32'h000000DE, 1'b1};
      tbl[9]  = '{1'b1, 2'd1, 1'b0, 32'h8000001C, 32'h56781234, LW,     1'b0, 32'h0,        1'b1};
      tbl[10] = '{1'b1, 2'd0, 1'b0, 32'h8000001E, 32'h12345677, LW,     1'b0, 32'h0,        1'b1};
      tbl[11] = '{1'b1, 2'd2, 1'b0, 32'h80000020, 32'hFFFFFFFF, LW,     1'b0, 32'h0,        1'b1};
      tbl[12] = '{1'b0, 2'd0, 1'b1, 32'h8000001D, 32'h0,        3'b011, 1'b1, 32'hDE771234, 1'b1};
      tbl[13] = '{1'b0, 2'd0, 1'b1, 32'h80000000, 32'h0,        LW,     1'b1, 32'h0,        1'b1};
      tbl[14] = '{1'b0, 2'd0, 1'b1, 32'h10000010, 32'h0,        LW,     1'b0, 32'h0,        1'b0};
      tbl[15] = '{1'b0, 2'd0, 1'b1, 32'h80000024, 32'h0,        LB,     1'b1, 32'h0,        1'b1};
      tbl[16] = '{1'b1, 2'd0, 1'b1, 32'h8000001D, 32'h00000011, LW,     1'b1, 32'hDE771234, 1'b1};
      tbl[17] = '{1'b0, 2'd0, 1'b1, 32'h8000001C, 32'h0,        LW,     1'b1, 32'hDE771134, 1'b1};
   end

   initial begin
      bit prev_re_in;
      ld_size = LW;
      idle();
      reset = 1'b1;
      model_reset();
      #12;
      check("reset rdata", rdata, 32'h0);
      check("reset hit", {31'h0, hit}, 32'h0);
      check("reset tohost", tohost, 32'h0);
      check("reset misalign", {31'h0, misalign}, 32'h0);

      // Cycle counter: 0 in cycle 0, so a load in cycle 9 returns 9.
      @(negedge clk);
      reset = 1'b0;
      repeat (9) clk_edge();
      set_in(1, 0, 32'h0, 32'h0, 2'd0);
      we = 0; re = 1; addr = 32'h80000010;
      clk_edge();
      idle(); ld_size = LW; #1;
      check("cycle count at 9", rdata, 32'd9);
      check("cycle count hit", {31'h0, hit}, 32'h1);

      // Directed vector table, starting from a clean scratch.
      do_reset();
      foreach (tbl[i]) begin
         set_in(tbl[i].we, tbl[i].re, tbl[i].addr, tbl[i].wdata, tbl[i].st);
         clk_edge();
         idle(); ld_size = tbl[i].lsz; #1;
         if (tbl[i].chk_rd) check($sformatf("vec%0d rdata", i), rdata, tbl[i].exp_rd);
         check($sformatf("vec%0d hit", i), {31'h0, hit}, {31'h0, tbl[i].exp_hit});
      end

      // Misaligned halfword store is dropped and misalign sticks.
      do_reset();
      check("misalign clear before", {31'h0, misalign}, 32'h0);
      set_in(1, 0, 32'h8000001F, 32'h00001234, 2'd1);
      clk_edge();
      idle(); #1;
      check("misalign set", {31'h0, misalign}, 32'h1);
      re = 1; addr = 32'h8000001C;
      clk_edge();
      idle(); ld_size = LW; #1;
      check("scratch after misaligned SH", rdata, 32'h0);
      for (int k = 0; k < 5; k++) begin
         clk_edge(); #1;
         check($sformatf("misalign sticky %0d", k), {31'h0, misalign}, 32'h1);
      end

      // Counter clear beats a same-edge retire pulse; run once per counter.
      for (int pass = 0; pass < 2; pass++) begin
         idle(); inst_retire = 1;
         repeat (5) clk_edge();
         idle(); re = 1; addr = 32'h80000014;
         clk_edge();
         idle(); ld_size = LW; #1;
         if (pass == 0) check("instret after 5 pulses", rdata, m_rd_word);
         set_in(1, 0, 32'h80000018, 32'h0, 2'd2); inst_retire = 1;
         clk_edge();
         idle(); re = 1; addr = (pass == 0) ? 32'h80000014 : 32'h80000010;
         clk_edge();
         idle(); ld_size = LW; #1;
         check(pass == 0 ? "instret after clear" : "cycle after clear", rdata, 32'h0);
      end

      // Out-of-region store to the clear address leaves counters running.
      set_in(1, 0, 32'h10000018, 32'h0, 2'd2);
      clk_edge();
      idle(); #1;
      check("oor store hit", {31'h0, hit}, 32'h0);
      re = 1; addr = 32'h80000010;
      clk_edge();
      idle(); ld_size = LW; #1;
      check("cycle after oor store", rdata, m_rd_word);

      // tohost write, then asynchronous reset mid-cycle with a store held across an edge.
      csr_we = 1; csr_wdata = 32'h1;
      clk_edge();
      idle(); #1;
      check("tohost written", tohost, 32'h1);
      check("misalign before async reset", {31'h0, misalign}, 32'h1);
      @(posedge clk); #3;
      reset = 1'b1;
      model_reset();
      #1;
      check("async reset tohost", tohost, 32'h0);
      check("async reset misalign", {31'h0, misalign}, 32'h0);
      check("async reset rdata", rdata, 32'h0);
      check("async reset hit", {31'h0, hit}, 32'h0);
      set_in(1, 0, 32'h8000001C, 32'hFFFFFFFF, 2'd2);
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      idle(); re = 1; addr = 32'h8000001C;
      clk_edge();
      idle(); ld_size = LW; #1;
      check("store during reset discarded", rdata, 32'h0);

      // Randomized traffic against the model.
      do_reset();
      idle();
      prev_re_in = 0;
      for (int it = 0; it < 800; it++) begin
         clk_edge();
         we = ($urandom_range(0, 2) == 0);
         re = ($urandom_range(0, 1) == 0);
         st_size = 2'($urandom_range(0, 3));
         addr = ($urandom_range(0, 7) == 0) ? {4'h1, 28'($urandom)}
                                            : (32'h80000000 | 32'($urandom_range(0, 63)));
         wdata = $urandom;
         inst_retire = ($urandom_range(0, 1) == 0);
         csr_we = ($urandom_range(0, 3) == 0);
         csr_wdata = $urandom;
         ld_size = 3'($urandom_range(0, 7));
         #1;
         check("rand hit", {31'h0, hit}, {31'h0, m_hit});
         check("rand tohost", tohost, m_tohost);
         check("rand misalign", {31'h0, misalign}, {31'h0, m_mis});
         if (prev_re_in) check("rand rdata", rdata, fmt(m_rd_word, m_rd_off, ld_size));
         prev_re_in = re && (addr[31:28] == 4'h8);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/mmio_responder.md
# mmio_responder

Memory-mapped I/O and CSR responder for the Riscv151 three-stage pipeline: the target end of the data-port write-enable, store-size and load-size controls and the CSR write-enable that the pipeline controller issues. Sits beside the data cache on the X-stage address bus. Decodes the 0x8xxxxxxx region and services byte-lane stores and synchronous sized loads. Holds the cycle counter, retired-instruction counter, a byte-writable scratch register and the tohost CSR.

## Interface
- CNT_W, 32, width of the cycle and instruction counters; reads zero-extend to 32
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high; one clock; reset is asynchronous and active-high
- addr  in  32  X-stage byte address (ALU result)
- wdata  in  32  X-stage store data, unshifted (rs2 value)
- we  in  1  store request, already qualified by instruction kill
- st_size  in  2  store func3[1:0]: 00 byte, 01 half, 10 word; 11 treated as word
- re  in  1  load request in X stage
- ld_size  in  3  M-stage load func3: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; others treated as LW
- inst_retire  in  1  one pulse per committed, non-killed instruction
- csr_we  in  1  tohost write enable (M stage)
- csr_wdata  in  32  tohost write data
- rdata  out  32  formatted load data, valid the cycle after re
- hit  out  1  registered: previous-cycle re or we addressed 0x8xxxxxxx
- tohost  out  32  tohost CSR value
- misalign  out  1  sticky: a misaligned store was dropped

## Operation
- Region decode: addr[31:28]==4'h8. Word decode uses addr[7:2]:
  - 0x80000010 cycle counter, RO
  - 0x80000014 instret counter, RO
  - 0x80000018 counter reset, WO; any store zeroes both counters
  - 0x8000001C scratch, RW, byte-lane writable
  - All other in-region words read 0; writes to them are ignored.
  - Out-of-region accesses are ignored and set hit=0.
- Store lane mask:
  - byte: 4'b0001<<addr[1:0], data replicated to all four lanes
  - half: 4'b0011<<{addr[1],1'b0}, data replicated to both halves
  - word: 4'b1111
- Misaligned store: half with addr[0]=1, or word with addr[1:0]!=0.
  - The write is dropped; no register changes, counters included.
  - misalign sets and stays set until reset.
- Load path:
  - At the clock edge, register the addressed word, addr[1:0] and the region hit.
  - rdata is combinational from the registered word, registered offset and the current ld_size.
  - Byte/half extraction shifts by the offset. LB/LH sign-extend; LBU/LHU zero-extend.
- Cycle counter: +1 every edge; wraps at 2^CNT_W.
- Instret counter: +1 on edges where inst_retire=1; wraps.
- Counter-reset store has priority over increment: both counters read 0 in the following cycle, even if inst_retire=1 in the same cycle.
- Simultaneous re and we, same or different word: the load captures the pre-write value; the write takes effect.
- tohost loads csr_wdata on an edge with csr_we=1. It is independent of the MMIO path.

## Timing
- Reset values: rdata word/offset registers 0, hit 0, tohost 0, misalign 0, counters 0. Asynchronous reset clears these immediately, without waiting for an edge.
- Cycle counter is 0 in the first cycle after reset deassertion.
- Load latency 1: re in cycle N returns rdata in cycle N+1. The returned value is the register state present during cycle N, before the edge.
- Store latency 1: the write is visible to a load issued in cycle N+1.
- hit and rdata hold their value until the next re or we; there is no valid strobe.
- Reset asserted mid-access: any pending load result is lost and rdata reads 0. A store on the same edge as reset is discarded.

## Test plan
- Cycle count: reset released; re to 0x80000010 in cycle 9 -> rdata=9 in cycle 10, hit=1.
- Byte lanes:
  - SB 0xA5 to 0x8000001D -> scratch=0x0000A500.
  - LB 0x8000001D -> rdata=0xFFFFFFA5; LBU -> 0x000000A5.
  - SW 0xDEADBEEF to 0x8000001C, then LH from 0x8000001E -> rdata=0xFFFFDEAD.
- Misaligned store: SH 0x1234 to 0x8000001F with scratch=0 -> scratch stays 0, misalign=1 next cycle and remains 1 across 5 further cycles.
- Counter reset: 5 inst_retire pulses, then a store to 0x80000018 in the same cycle as a 6th pulse -> load of 0x80000014 next cycle returns 0. A load of 0x80000010 issued in that same next cycle also returns 0.
- tohost and async reset: csr_we=1, csr_wdata=0x1 -> tohost=0x1 next cycle. Assert reset mid-cycle -> tohost=0 and misalign=0 before the next edge.
- Decode:
  - re to 0x80000000 -> rdata=0, hit=1.
  - re to 0x10000010 -> hit=0.
  - SW to 0x10000018 -> counters keep counting.
